latch_bank_arbiter: RTL

- Arbitrates write access from several requesters to a shared bank of clear-able transparent D-latches (`d`, `clk`, `clr` primitives).
- Grants one requester at a time, round-robin.
- Sequences each write as setup → open → hold so latch data is stable around the enable window.
- Owns the bank's clear line: the latches are cleared on reset and, optionally, on command.

---
 rtl/latch_bank_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin write arbiter in front of a shared bank of
// clear-able transparent D-latches. Every write runs setup -> open -> hold so
// the latch data is stable on both sides of the enable window.
// Optional feature macro: LBA_CLEAR_EN adds the clr_req/clr_ack ports and a
// CLEAR state; without it lat_clr is driven by reset alone.

module latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int NLAT      = 8,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1,
  localparam int AW       = $clog2(NLAT)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               err,
  output logic               busy,
  output logic [DW-1:0]      lat_d,
  output logic [NLAT-1:0]    lat_en,
  output logic               lat_clr
`ifdef LBA_CLEAR_EN
  ,
  input  logic               clr_req,
  output logic               clr_ack
`endif
);

  localparam int PW   = $clog2(NREQ);
  localparam int MAXC = (SETUP_CYC > OPEN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   NLAT_W   = (AW + 1)'(NLAT);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

`ifdef LBA_CLEAR_EN
  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;
`endif

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   cap_idx;
  logic [AW-1:0]   cap_addr;
  logic            warm;

  logic [PW-1:0]   pick_hi;
  logic [PW-1:0]   pick_lo;
  logic            hi_ok;
  logic            lo_ok;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   nxt_ptr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NLAT-1:0] en_mask;
  logic [NREQ-1:0] gnt_mask;
  logic            addr_bad;

  // Round-robin pick: lowest asserted request at or above ptr, else the lowest overall
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_ok   = 1'b0;
    lo_ok   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = PW'(i);
        lo_ok   = 1'b1;
        if (PW'(i) >= ptr) begin
          pick_hi = PW'(i);
          hi_ok   = 1'b1;
        end
      end
    end
    winner  = hi_ok ? pick_hi : pick_lo;
    nxt_ptr = (winner == LAST_REQ) ? '0 : winner + PW'(1);
  end

  // Select the winning requester's address and data slices
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Decode the captured transaction into enable and grant masks
  always_comb begin
    en_mask  = '0;
    gnt_mask = '0;
    addr_bad = ({1'b0, cap_addr} >= NLAT_W);
    for (int i = 0; i < NLAT; i++) begin
      en_mask[i] = (cap_addr == AW'(i));
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt_mask[i] = (cap_idx == PW'(i));
    end
  end

  // Transaction FSM with all outputs registered; reset clears the bank and aborts any write
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_addr <= '0;
      warm     <= 1'b1;
      gnt      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      lat_d    <= '0;
      lat_en   <= '0;
      lat_clr  <= 1'b1;
`ifdef LBA_CLEAR_EN
      clr_ack  <= 1'b0;
`endif
    end else if (warm) begin
      warm    <= 1'b0;
      lat_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef LBA_CLEAR_EN
          if (clr_req) begin
            state   <= CLEAR;
            cnt     <= OPEN_LD;
            busy    <= 1'b1;
            lat_clr <= 1'b1;
            clr_ack <= (OPEN_CYC == 1);
          end else
`endif
          if (lo_ok) begin
            state    <= SETUP;
            cnt      <= SETUP_LD;
            busy     <= 1'b1;
            cap_idx  <= winner;
            cap_addr <= sel_addr;
            lat_d    <= sel_data;
            ptr      <= nxt_ptr;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= OPEN;
            cnt    <= OPEN_LD;
            lat_en <= en_mask;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        OPEN: begin
          if (cnt == '0) begin
            state  <= HOLD;
            cnt    <= HOLD_LD;
            lat_en <= '0;
            if (HOLD_CYC == 1) begin
              gnt <= gnt_mask;
              err <= addr_bad;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
            err   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              gnt <= gnt_mask;
              err <= addr_bad;
            end
          end
        end
`ifdef LBA_CLEAR_EN
        CLEAR: begin
          if (cnt == '0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            lat_clr <= 1'b0;
            clr_ack <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              clr_ack <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
